mips_cpu_load_store_unit: RTL and testbench
===========================================

# mips_cpu_load_store_unit

Memory-access stage between the execute stage and the register file. Accepts one load or store request at a time and runs it as a single Avalon-MM transfer, honouring `waitrequest`. On load completion it returns lane-aligned data, the destination register and the opcode, ready to drive the register file's `writedata`, `writereg`, `regwrite` and `opcode` inputs. The register file performs sign or zero extension and the `lwl`/`lwr` merging.

## Interface
- No parameters; data width 32, address width 32.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; a transfer occurs when `req_valid && req_ready`.
- `req_opcode` in 6: MIPS primary opcode.
- `req_addr` in 32: effective byte address.
- `req_wdata` in 32: store data (rt value).
- `req_rt` in 5: destination register for loads.
- `avm_address` out 32: word-aligned address, `{req_addr[31:2],2'b00}`.
- `avm_read` out 1: Avalon read strobe.
- `avm_write` out 1: Avalon write strobe.
- `avm_byteenable` out 4: Avalon byte-lane enables.
- `avm_writedata` out 32: Avalon write data.
- `avm_readdata` in 32: Avalon read data.
- `avm_waitrequest` in 1: Avalon wait request.
- `rsp_valid` out 1: one-cycle completion pulse for every request.
- `rsp_regwrite` out 1: high with `rsp_valid` for successful loads only.
- `rsp_data` out 32: aligned load data.
- `rsp_rt` out 5: destination register number.
- `rsp_opcode` out 6: opcode of the completed request.
- `rsp_err` out 1: misaligned or unsupported request; pulses with `rsp_valid`.
- `busy` out 1: high in any state other than IDLE; used as the pipeline stall.

## Operation
- Supported opcodes:
  - Loads: `lb` 100000, `lh` 100001, `lwl` 100010, `lw` 100011, `lbu` 100100, `lhu` 100101, `lwr` 100110.
  - Stores: `sb` 101000, `sh` 101001, `sw` 101011.
- Byte lanes are little-endian: lane k is bits [8k+7:8k]. `a` = `req_addr[1:0]`.
- Byte enables:
  - `lb`/`lbu`/`sb`: `4'b0001<<a`.
  - `lh`/`lhu`/`sh`: `a[1]` ? `4'b1100` : `4'b0011`.
  - `lw`/`sw`/`lwl`/`lwr`: `4'b1111`.
- Store data:
  - `sb`: byte replicated on all four lanes.
  - `sh`: half replicated on both halves.
  - `sw`: passed through unchanged.
- Load data:
  - `lb`/`lbu`: selected byte in [7:0].
  - `lh`/`lhu`: selected half in [15:0].
  - `lw`/`lwl`/`lwr`: raw word.
  - All upper bits not supplied by the lane are zero.
- Errors:
  - `lh`/`lhu`/`sh` with `a[0]=1` is misaligned.
  - `lw`/`sw` with `a!=0` is misaligned.
  - Any other opcode is unsupported.
  - In all three cases no bus cycle is issued; go straight to DONE with `rsp_err=1`, `rsp_regwrite=0`, `rsp_data=0`.
- FSM: IDLE -> (accept) -> READ | WRITE | DONE(error); READ/WRITE -> DONE when `avm_waitrequest==0`; DONE -> IDLE unconditionally.
- On accept, register opcode, address, lane data, byteenable and rt. All Avalon outputs are driven from these registers and stay stable while `waitrequest` is high.
- `avm_readdata` is captured in the READ cycle where `waitrequest==0`.

## Timing
- Reset values:
  - IDLE state.
  - `avm_read`, `avm_write`, `rsp_*`, `busy` = 0; `req_ready`=1.
  - `avm_address`, `avm_writedata`, `avm_byteenable` = 0.
- Zero-wait access:
  - accept at edge N;
  - `avm_read`/`avm_write` high during cycle N+1;
  - `rsp_valid` high during cycle N+2;
  - `req_ready` high again in cycle N+3.
- Each `waitrequest` cycle adds exactly one cycle of latency.
- Error path: `rsp_valid` in cycle N+1.
- Strobes deassert in the cycle after the one with `waitrequest==0`; exactly one bus transaction per request.
- Reset asserted mid-transfer: all strobes drop immediately and asynchronously; the request is discarded with no `rsp_valid`.
- `req_valid` while `busy`: ignored, with no state change.

## Structure
- Shared package `mips_cpu_pkg`: opcode localparams and the `lsu_state_t` enum (IDLE, READ, WRITE, DONE).
- Sub-module `mips_cpu_lsu_lane_align`: purely combinational. Computes byteenable, store replication, load lane extraction and misalignment detection from opcode, `a` and data.
- Top level: FSM and registers only.

## Test plan
- `lbu` at `0x1003`, readdata `0xAABBCCDD`, waitrequest=0 -> byteenable `1000`; `rsp_data=0x000000AA`, `rsp_regwrite=1` at N+2.
- `lh` at `0x2002`, readdata `0x8001_1234`, waitrequest high for 3 cycles -> `avm_read` held for 4 cycles with stable address `0x2000`; `rsp_data=0x00008001` at N+5.
- `sb` at `0x0001` with wdata `0x12345678` -> byteenable `0010`, writedata `0x78787878`, `rsp_regwrite=0`.
- `lw` at `0x0006` -> no bus strobe; `rsp_valid=1`, `rsp_err=1` at N+1.
- `rst_n` dropped while `avm_read` is held by waitrequest -> `avm_read=0` within the same cycle; no `rsp_valid`; `req_ready=1` after release.
- Back-to-back `sw`, `lwl` requests with `req_valid` held high -> second accepted only after DONE; `lwl` returns the raw word with `rsp_opcode=100010`.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared opcodes and state encoding for the MIPS load/store unit.
package mips_cpu_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LWL = 6'b100010;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LWR = 6'b100110;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } lsu_state_t;

endpackage

// File: rtl/mips_cpu_lsu_lane_align.sv
// Combinational byte-lane logic: byteenables, store replication, load
// extraction and misalignment/unsupported-opcode detection.
module mips_cpu_lsu_lane_align
   import mips_cpu_pkg::*;
(
   input  logic [5:0]  req_opcode_i,
   input  logic [1:0]  req_a_i,
   input  logic [31:0] req_wdata_i,
   input  logic [5:0]  ld_opcode_i,
   input  logic [1:0]  ld_a_i,
   input  logic [31:0] ld_rdata_i,
   output logic [3:0]  byteenable_o,
   output logic [31:0] wdata_o,
   output logic        is_load_o,
   output logic        is_store_o,
   output logic        err_o,
   output logic [31:0] ld_data_o
);

   // Request-side decode: lanes, replicated store data, error flag.
   always_comb begin
      byteenable_o = 4'b0000;
      wdata_o      = 32'd0;
      is_load_o    = 1'b0;
      is_store_o   = 1'b0;
      err_o        = 1'b0;
      case (req_opcode_i)
         OP_LB, OP_LBU: begin
            byteenable_o = 4'b0001 << req_a_i;
            is_load_o    = 1'b1;
         end
         OP_SB: begin
            byteenable_o = 4'b0001 << req_a_i;
            wdata_o      = {4{req_wdata_i[7:0]}};
            is_store_o   = 1'b1;
         end
         OP_LH, OP_LHU: begin
            byteenable_o = req_a_i[1] ? 4'b1100 : 4'b0011;
            err_o        = req_a_i[0];
            is_load_o    = 1'b1;
         end
         OP_SH: begin
            byteenable_o = req_a_i[1] ? 4'b1100 : 4'b0011;
            wdata_o      = {2{req_wdata_i[15:0]}};
            err_o        = req_a_i[0];
            is_store_o   = 1'b1;
         end
         OP_LW: begin
            byteenable_o = 4'b1111;
            err_o        = (req_a_i != 2'b00);
            is_load_o    = 1'b1;
         end
         // lwl/lwr are merged by the register file, so any offset is legal
         OP_LWL, OP_LWR: begin
            byteenable_o = 4'b1111;
            is_load_o    = 1'b1;
         end
         OP_SW: begin
            byteenable_o = 4'b1111;
            wdata_o      = req_wdata_i;
            err_o        = (req_a_i != 2'b00);
            is_store_o   = 1'b1;
         end
         default: begin
            err_o = 1'b1;
         end
      endcase
   end

   // Load-side extraction of the addressed lane(s) into the low bits.
   always_comb begin
      ld_data_o = ld_rdata_i;
      case (ld_opcode_i)
         OP_LB, OP_LBU: begin
            case (ld_a_i)
               2'd0:    ld_data_o = {24'd0, ld_rdata_i[7:0]};
               2'd1:    ld_data_o = {24'd0, ld_rdata_i[15:8]};
               2'd2:    ld_data_o = {24'd0, ld_rdata_i[23:16]};
               default: ld_data_o = {24'd0, ld_rdata_i[31:24]};
            endcase
         end
         OP_LH, OP_LHU: begin
            ld_data_o = ld_a_i[1] ? {16'd0, ld_rdata_i[31:16]} : {16'd0, ld_rdata_i[15:0]};
         end
         default: begin
            ld_data_o = ld_rdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Memory-access stage: runs one load/store as a single Avalon-MM transfer
// and returns lane-aligned load data to the register file.
module mips_cpu_load_store_unit
   import mips_cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_opcode,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rt,
   output logic [31:0] avm_address,
   output logic        avm_read,
   output logic        avm_write,
   output logic [3:0]  avm_byteenable,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        rsp_valid,
   output logic        rsp_regwrite,
   output logic [31:0] rsp_data,
   output logic [4:0]  rsp_rt,
   output logic [5:0]  rsp_opcode,
   output logic        rsp_err,
   output logic        busy
);

   lsu_state_t  state_q, state_d;
   logic [5:0]  opcode_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;
   logic [4:0]  rt_q;
   logic        read_q, write_q;
   logic        rsp_valid_q, rsp_regwrite_q, rsp_err_q;
   logic [31:0] rsp_data_q;

   logic        accept_s, rd_done_s, wr_done_s, rsp_clr_s;
   logic [3:0]  lane_be_s;
   logic [31:0] lane_wdata_s, ld_data_s;
   logic        is_load_s, is_store_s, err_s;

   mips_cpu_lsu_lane_align u_align (
      .req_opcode_i (req_opcode),
      .req_a_i      (req_addr[1:0]),
      .req_wdata_i  (req_wdata),
      .ld_opcode_i  (opcode_q),
      .ld_a_i       (addr_q[1:0]),
      .ld_rdata_i   (avm_readdata),
      .byteenable_o (lane_be_s),
      .wdata_o      (lane_wdata_s),
      .is_load_o    (is_load_s),
      .is_store_o   (is_store_s),
      .err_o        (err_s),
      .ld_data_o    (ld_data_s)
   );

   // Next-state decode and datapath load strobes.
   always_comb begin
      state_d   = state_q;
      accept_s  = 1'b0;
      rd_done_s = 1'b0;
      wr_done_s = 1'b0;
      rsp_clr_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               accept_s = 1'b1;
               if (err_s)           state_d = DONE;
               else if (is_load_s)  state_d = READ;
               else if (is_store_s) state_d = WRITE;
               else                 state_d = DONE;
            end else begin
               state_d = IDLE;
            end
         end
         READ: begin
            if (!avm_waitrequest) begin
               rd_done_s = 1'b1;
               state_d   = DONE;
            end else begin
               state_d = READ;
            end
         end
         WRITE: begin
            if (!avm_waitrequest) begin
               wr_done_s = 1'b1;
               state_d   = DONE;
            end else begin
               state_d = WRITE;
            end
         end
         DONE: begin
            rsp_clr_s = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, request capture, bus strobes and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         opcode_q       <= 6'd0;
         addr_q         <= 32'd0;
         wdata_q        <= 32'd0;
         be_q           <= 4'd0;
         rt_q           <= 5'd0;
         read_q         <= 1'b0;
         write_q        <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_regwrite_q <= 1'b0;
         rsp_err_q      <= 1'b0;
         rsp_data_q     <= 32'd0;
      end else begin
         state_q <= state_d;
         if (accept_s) begin
            opcode_q       <= req_opcode;
            addr_q         <= req_addr;
            wdata_q        <= lane_wdata_s;
            be_q           <= lane_be_s;
            rt_q           <= req_rt;
            read_q         <= (state_d == READ);
            write_q        <= (state_d == WRITE);
            // errors skip the bus and respond in the very next cycle
            rsp_valid_q    <= (state_d == DONE);
            rsp_err_q      <= (state_d == DONE);
            rsp_regwrite_q <= 1'b0;
            rsp_data_q     <= 32'd0;
         end else if (rd_done_s) begin
            read_q         <= 1'b0;
            rsp_valid_q    <= 1'b1;
            rsp_regwrite_q <= 1'b1;
            rsp_err_q      <= 1'b0;
            rsp_data_q     <= ld_data_s;
         end else if (wr_done_s) begin
            write_q        <= 1'b0;
            rsp_valid_q    <= 1'b1;
            rsp_regwrite_q <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_data_q     <= 32'd0;
         end else if (rsp_clr_s) begin
            rsp_valid_q    <= 1'b0;
            rsp_regwrite_q <= 1'b0;
            rsp_err_q      <= 1'b0;
         end else begin
            read_q  <= read_q;
            write_q <= write_q;
         end
      end
   end

   assign req_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign avm_address    = {addr_q[31:2], 2'b00};
   assign avm_read       = read_q;
   assign avm_write      = write_q;
   assign avm_byteenable = be_q;
   assign avm_writedata  = wdata_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_regwrite   = rsp_regwrite_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_rt         = rt_q;
   assign rsp_opcode     = opcode_q;
   assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// Directed plus randomized bench for mips_cpu_load_store_unit with a
// size/offset arithmetic reference model.
module tb_mips_cpu_load_store_unit;

   logic        clk, rst_n, req_valid, req_ready;
   logic [5:0]  req_opcode;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rt;
   logic [31:0] avm_address, avm_writedata, avm_readdata;
   logic        avm_read, avm_write, avm_waitrequest;
   logic [3:0]  avm_byteenable;
   logic        rsp_valid, rsp_regwrite, rsp_err, busy;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rt;
   logic [5:0]  rsp_opcode;

   int vectors;
   int miscompares;

   mips_cpu_load_store_unit dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
      .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
      .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest),
      .rsp_valid(rsp_valid), .rsp_regwrite(rsp_regwrite), .rsp_data(rsp_data),
      .rsp_rt(rsp_rt), .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Access size in bytes (0 = unsupported opcode).
   function automatic int op_size(input logic [5:0] op);
      case (op)
         6'b100000, 6'b100100, 6'b101000: return 1;
         6'b100001, 6'b100101, 6'b101001: return 2;
         6'b100011, 6'b101011, 6'b100010, 6'b100110: return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit op_is_store(input logic [5:0] op);
      return (op == 6'b101000) || (op == 6'b101001) || (op == 6'b101011);
   endfunction

   function automatic bit op_unaligned_ok(input logic [5:0] op);
      return (op == 6'b100010) || (op == 6'b100110);
   endfunction

   // Applies one request from an idle DUT and checks every cycle until idle again.
   task automatic run_req(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input logic [4:0] rt, input int nwait);
      int          size, a, off;
      bit          err, st;
      logic [31:0] mask, exp_be, exp_wd, exp_data;
      size = op_size(op);
      a    = int'(addr[1:0]);
      st   = op_is_store(op);
      err  = (size == 0) || (!op_unaligned_ok(op) && (a % size) != 0);
      off  = (size == 4) ? 0 : a;
      mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      exp_be   = (size == 4) ? 32'hF : (((32'd1 << size) - 32'd1) << off);
      exp_data = (rd >> (8 * off)) & mask;
      if (size == 1)      exp_wd = {24'd0, wd[7:0]} * 32'h0101_0101;
      else if (size == 2) exp_wd = {16'd0, wd[15:0]} * 32'h0001_0001;
      else                exp_wd = wd;

      chk("ready_before", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_opcode = op; req_addr = addr; req_wdata = wd; req_rt = rt;
      avm_readdata = rd; avm_waitrequest = (nwait > 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_opcode = 6'($urandom); req_addr = $urandom; req_wdata = $urandom;
      if (err) begin
         chk("err_valid", 32'(rsp_valid), 32'd1);
         chk("err_flag", 32'(rsp_err), 32'd1);
         chk("err_regwrite", 32'(rsp_regwrite), 32'd0);
         chk("err_data", rsp_data, 32'd0);
         chk("err_strobes", {30'd0, avm_read, avm_write}, 32'd0);
         chk("err_opcode", 32'(rsp_opcode), 32'(op));
      end else begin
         for (int i = 0; i <= nwait; i++) begin
            chk("bus_read", 32'(avm_read), 32'(!st));
            chk("bus_write", 32'(avm_write), 32'(st));
            chk("bus_addr", avm_address, {addr[31:2], 2'b00});
            chk("bus_be", 32'(avm_byteenable), exp_be);
            if (st) chk("bus_wdata", avm_writedata, exp_wd);
            chk("bus_no_rsp", 32'(rsp_valid), 32'd0);
            chk("bus_busy", 32'(busy), 32'd1);
            @(posedge clk); #1;
            avm_waitrequest = ((i + 1) < nwait);
         end
         chk("rsp_valid", 32'(rsp_valid), 32'd1);
         chk("rsp_err", 32'(rsp_err), 32'd0);
         chk("rsp_regwrite", 32'(rsp_regwrite), 32'(!st));
         chk("rsp_opcode", 32'(rsp_opcode), 32'(op));
         chk("rsp_strobes", {30'd0, avm_read, avm_write}, 32'd0);
         if (!st) begin
            chk("rsp_data", rsp_data, exp_data);
            chk("rsp_rt", 32'(rsp_rt), 32'(rt));
         end
      end
      @(posedge clk); #1;
      chk("ready_after", 32'(req_ready), 32'd1);
      chk("rsp_cleared", 32'(rsp_valid), 32'd0);
   endtask

   logic [5:0] ops [12];

   initial begin
      vectors = 0; miscompares = 0;
      ops = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100, 6'b100101,
              6'b100110, 6'b101000, 6'b101001, 6'b101011, 6'b000000, 6'b101110};
      rst_n = 1'b0; req_valid = 1'b0; req_opcode = 6'd0; req_addr = 32'd0;
      req_wdata = 32'd0; req_rt = 5'd0; avm_readdata = 32'd0; avm_waitrequest = 1'b0;
      #2;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", {30'd0, avm_read, avm_write}, 32'd0);
      chk("rst_rsp", {28'd0, rsp_valid, rsp_regwrite, rsp_err, 1'b0}, 32'd0);
      chk("rst_addr", avm_address, 32'd0);
      chk("rst_wdata", avm_writedata, 32'd0);
      chk("rst_be", 32'(avm_byteenable), 32'd0);
      @(posedge clk); #1; rst_n = 1'b1;
      @(posedge clk); #1;

      run_req(6'b100100, 32'h0000_1003, 32'h0, 32'hAABB_CCDD, 5'd7, 0);
      run_req(6'b100001, 32'h0000_2002, 32'h0, 32'h8001_1234, 5'd9, 3);
      run_req(6'b101000, 32'h0000_0001, 32'h1234_5678, 32'h0, 5'd3, 0);
      run_req(6'b100011, 32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 5'd4, 0);

      // reset while a read is stalled by waitrequest
      req_valid = 1'b1; req_opcode = 6'b100001; req_addr = 32'h0000_3002; req_rt = 5'd5;
      avm_waitrequest = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      chk("rstx_read_on", 32'(avm_read), 32'd1);
      @(posedge clk); #3;
      rst_n = 1'b0; #1;
      chk("rstx_read_drop", 32'(avm_read), 32'd0);
      chk("rstx_busy", 32'(busy), 32'd0);
      chk("rstx_no_rsp", 32'(rsp_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; avm_waitrequest = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("rstx_quiet", {30'd0, rsp_valid, avm_read}, 32'd0);
         chk("rstx_ready", 32'(req_ready), 32'd1);
      end

      // back-to-back sw then lwl with req_valid held high
      req_valid = 1'b1; req_opcode = 6'b101011; req_addr = 32'h0000_4000;
      req_wdata = 32'hCAFE_F00D; req_rt = 5'd1; avm_readdata = 32'h1122_3344;
      @(posedge clk); #1;
      req_opcode = 6'b100010; req_addr = 32'h0000_5001; req_rt = 5'd17;
      chk("b2b_write", 32'(avm_write), 32'd1);
      chk("b2b_wdata", avm_writedata, 32'hCAFE_F00D);
      chk("b2b_ready_wr", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("b2b_sw_rsp", 32'(rsp_valid), 32'd1);
      chk("b2b_ready_done", 32'(req_ready), 32'd0);
      chk("b2b_no_read", 32'(avm_read), 32'd0);
      @(posedge clk); #1;
      chk("b2b_ready_idle", 32'(req_ready), 32'd1);
      @(posedge clk); #1; req_valid = 1'b0;
      chk("b2b_lwl_read", 32'(avm_read), 32'd1);
      chk("b2b_lwl_addr", avm_address, 32'h0000_5000);
      chk("b2b_lwl_be", 32'(avm_byteenable), 32'hF);
      @(posedge clk); #1;
      chk("b2b_lwl_valid", 32'(rsp_valid), 32'd1);
      chk("b2b_lwl_data", rsp_data, 32'h1122_3344);
      chk("b2b_lwl_opcode", 32'(rsp_opcode), 32'(6'b100010));
      chk("b2b_lwl_rt", 32'(rsp_rt), 32'd17);
      @(posedge clk); #1;

      for (int n = 0; n < 300; n++) begin
         run_req(ops[$urandom_range(0, 11)], $urandom, $urandom, $urandom,
                 5'($urandom), $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
